ps2_keycode_rx: RTL and testbench

- PS/2 keyboard front end.
- Samples the raw PS/2 clock/data pins, assembles and checks 11-bit device-to-host frames, and tracks the set-2 make/break/extended prefixes.
- Converts hex-digit and Enter make codes into a one-cycle event with a 4-bit value and two type flags.
- Feeds the digit shift register (flags[0]) and the calculator FSM (flags[1]), running on the 100 MHz system clock.

---
 rtl/ps2_keycode_rx_pkg.sv | 46 ++++
 rtl/ps2_frame_shifter.sv | 128 ++++++++++++
 rtl/ps2_keycode_rx.sv | 105 ++++++++++
 tb/tb_ps2_keycode_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_keycode_rx_pkg.sv
// Shared definitions for the PS/2 keycode receiver: frame FSM states,
// set-2 prefix codes, output flag positions and the hex-key lookup.
package ps2_keycode_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    CHECK  = 3'd4
  } frame_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int FLAG_DIGIT = 0;
  localparam int FLAG_ENTER = 1;

  // Returns {hit, value}: hit=1 when the set-2 make code is a hex-digit key.
  function automatic logic [4:0] hex_of_code(input logic [7:0] code);
    logic [4:0] res;
    res = 5'b0_0000;
    case (code)
      8'h45: res = 5'b1_0000;
      8'h16: res = 5'b1_0001;
      8'h1E: res = 5'b1_0010;
      8'h26: res = 5'b1_0011;
      8'h25: res = 5'b1_0100;
      8'h2E: res = 5'b1_0101;
      8'h36: res = 5'b1_0110;
      8'h3D: res = 5'b1_0111;
      8'h3E: res = 5'b1_1000;
      8'h46: res = 5'b1_1001;
      8'h1C: res = 5'b1_1010;
      8'h32: res = 5'b1_1011;
      8'h21: res = 5'b1_1100;
      8'h23: res = 5'b1_1101;
      8'h24: res = 5'b1_1110;
      8'h2B: res = 5'b1_1111;
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_frame_shifter.sv
// PS/2 device-to-host frame receiver: input synchronizers, falling-edge
// detect, 11-bit frame FSM with odd-parity/stop check and an inactivity
// timeout. byte_valid is high during the CHECK cycle of a good frame.
// Optional macro PS2_FRAME_ERR_EN adds the frame_err pulse output.
import ps2_keycode_rx_pkg::*;

module ps2_frame_shifter #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_clk,
  input  logic       PS2_dat,
  output logic       byte_valid,
`ifdef PS2_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output logic [7:0] data_byte
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s;
  logic                   dat_s;
  logic                   falling;
  logic                   busy;
  logic                   timeout_hit;
  logic                   frame_good;

  frame_state_t    state_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            parity_reg;
  logic            stop_reg;
  logic [TO_W-1:0] to_cnt_reg;

  assign clk_s       = clk_sync_reg[SYNC_STAGES-1];
  assign dat_s       = dat_sync_reg[SYNC_STAGES-1];
  assign falling     = clk_prev_reg & ~clk_s;
  assign busy        = (state_reg == DATA) || (state_reg == PARITY) || (state_reg == STOP);
  assign timeout_hit = busy && !falling && (to_cnt_reg == TO_LAST);
  // Odd parity: the eight data bits plus the parity bit hold an odd count of ones.
  assign frame_good  = stop_reg && (^{shift_reg, parity_reg});
  assign byte_valid  = (state_reg == CHECK) && frame_good;
  assign data_byte   = shift_reg;

`ifdef PS2_FRAME_ERR_EN
  assign frame_err = ((state_reg == CHECK) && !frame_good) || timeout_hit;
`endif

  // Synchronize both pins (idle-high reset) and remember the previous clock level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], PS2_clk};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], PS2_dat};
      clk_prev_reg <= clk_s;
    end
  end

  // Frame FSM with the inactivity counter; a timeout overrides the bit step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      stop_reg    <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      if (!busy || falling) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (timeout_hit) begin
        state_reg  <= IDLE;
        to_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (falling && !dat_s) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            if (falling) begin
              shift_reg   <= {dat_s, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == 3'd7) begin
                state_reg <= PARITY;
              end
            end
          end
          PARITY: begin
            if (falling) begin
              parity_reg <= dat_s;
              state_reg  <= STOP;
            end
          end
          STOP: begin
            if (falling) begin
              stop_reg  <= dat_s;
              state_reg <= CHECK;
            end
          end
          CHECK: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard front end: receives set-2 scan codes, tracks the E0/F0
// prefixes and turns hex-digit and Enter make codes into a one-cycle
// R_O strobe with a 4-bit value and digit/Enter flags.
// Optional macro PS2_FRAME_ERR_EN adds frame_err and a saturating err_cnt.
import ps2_keycode_rx_pkg::*;

module ps2_keycode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_clk,
  input  logic       PS2_dat,
`ifdef PS2_FRAME_ERR_EN
  output logic       frame_err,
  output logic [7:0] err_cnt,
`endif
  output logic       R_O,
  output logic [3:0] out,
  output logic [1:0] flags
);

  logic       byte_valid;
  logic [7:0] data_byte;
  logic [4:0] hex_hit;
  logic       ext_reg;
  logic       brk_reg;

`ifdef PS2_FRAME_ERR_EN
  logic shifter_err;
`endif

  ps2_frame_shifter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .PS2_clk    (PS2_clk),
    .PS2_dat    (PS2_dat),
    .byte_valid (byte_valid),
`ifdef PS2_FRAME_ERR_EN
    .frame_err  (shifter_err),
`endif
    .data_byte  (data_byte)
  );

  assign hex_hit = hex_of_code(data_byte);

  // Prefix tracking and make-code mapping; R_O is a single-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R_O     <= 1'b0;
      out     <= '0;
      flags   <= '0;
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else begin
      R_O <= 1'b0;
      if (byte_valid) begin
        if (data_byte == SC_EXT) begin
          ext_reg <= 1'b1;
        end else if (data_byte == SC_BREAK) begin
          brk_reg <= 1'b1;
        end else if (brk_reg) begin
          // Release code of a key: swallow it and drop both prefixes.
          brk_reg <= 1'b0;
          ext_reg <= 1'b0;
        end else begin
          ext_reg <= 1'b0;
          if (data_byte == SC_ENTER) begin
            R_O               <= 1'b1;
            out               <= 4'h0;
            flags             <= '0;
            flags[FLAG_ENTER] <= 1'b1;
          end else if (hex_hit[4] && !ext_reg) begin
            R_O               <= 1'b1;
            out               <= hex_hit[3:0];
            flags             <= '0;
            flags[FLAG_DIGIT] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PS2_FRAME_ERR_EN
  // Register the error pulse and keep a saturating error count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= shifter_err;
      if (shifter_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx. The PS/2 bit period is shortened to
// 80 system clocks and the timeout to 2000 clocks to keep the run short.
module tb_ps2_keycode_rx;

  localparam int HALF    = 40;
  localparam int TIMEOUT = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PS2_clk = 1'b1;
  logic       PS2_dat = 1'b1;
  logic       R_O;
  logic [3:0] out;
  logic [1:0] flags;
`ifdef PS2_FRAME_ERR_EN
  logic       frame_err;
  logic [7:0] err_cnt;
  int         err_pulses = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int ev_cyc = 0;
  int stop_cyc = 0;
  logic [3:0] ev_out = '0;
  logic [1:0] ev_flags = '0;
  int base;

  ps2_keycode_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TO_W           (11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PS2_clk   (PS2_clk),
    .PS2_dat   (PS2_dat),
`ifdef PS2_FRAME_ERR_EN
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
`endif
    .R_O       (R_O),
    .out       (out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe, sampled on the falling system-clock edge.
  always @(negedge clk) begin
    if (R_O === 1'b1) begin
      ev_cnt   = ev_cnt + 1;
      ev_cyc   = cyc;
      ev_out   = out;
      ev_flags = flags;
    end
`ifdef PS2_FRAME_ERR_EN
    if (frame_err === 1'b1) err_pulses = err_pulses + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Drive the first nbits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input logic flip_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      PS2_dat = fr[i];
      repeat (HALF) @(negedge clk);
      PS2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      PS2_clk = 1'b1;
    end
    PS2_dat = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_R_O", {31'd0, R_O}, 32'd0);
    check("reset_out", {28'd0, out}, 32'd0);
    check("reset_flags", {30'd0, flags}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Digit 1: timing and value
    base = ev_cnt;
    send_frame(8'h16);
    check("k16_events", ev_cnt - base, 1);
    check("k16_latency", ev_cyc - stop_cyc, 4);
    check("k16_out", {28'd0, ev_out}, 32'h1);
    check("k16_flags", {30'd0, ev_flags}, 32'h1);

    // Make A then its break: one event only
    base = ev_cnt;
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("brk_events", ev_cnt - base, 1);
    check("brk_out", {28'd0, ev_out}, 32'hA);
    check("brk_flags", {30'd0, ev_flags}, 32'h1);

    // Keypad Enter then main Enter
    base = ev_cnt;
    send_frame(8'hE0);
    send_frame(8'h5A);
    send_frame(8'h5A);
    check("ent_events", ev_cnt - base, 2);
    check("ent_out", {28'd0, ev_out}, 32'h0);
    check("ent_flags", {30'd0, ev_flags}, 32'h2);

    // Extended digit code yields nothing
    base = ev_cnt;
    send_frame(8'hE0);
    send_frame(8'h16);
    check("ext_digit_events", ev_cnt - base, 0);

    // Bad parity dropped, then a good 0x45
    base = ev_cnt;
    send_bits(8'h45, 1'b1, 11);
    check("badpar_events", ev_cnt - base, 0);
`ifdef PS2_FRAME_ERR_EN
    check("badpar_pulses", err_pulses, 1);
    check("badpar_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
    send_frame(8'h45);
    check("k45_events", ev_cnt - base, 1);
    check("k45_out", {28'd0, ev_out}, 32'h0);
    check("k45_flags", {30'd0, ev_flags}, 32'h1);

    // Partial frame abandoned by timeout
    base = ev_cnt;
    send_bits(8'h2B, 1'b0, 5);
    repeat (TIMEOUT + 100) @(negedge clk);
    check("timeout_events", ev_cnt - base, 0);
`ifdef PS2_FRAME_ERR_EN
    check("timeout_err_cnt", {24'd0, err_cnt}, 32'd2);
`endif
    send_frame(8'h2B);
    check("k2B_events", ev_cnt - base, 1);
    check("k2B_out", {28'd0, ev_out}, 32'hF);
    check("k2B_flags", {30'd0, ev_flags}, 32'h1);

    // Reset in the middle of a frame clears outputs at once
    send_bits(8'h26, 1'b0, 6);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_R_O", {31'd0, R_O}, 32'd0);
    check("midrst_out", {28'd0, out}, 32'd0);
    check("midrst_flags", {30'd0, flags}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    base = ev_cnt;
    send_frame(8'h26);
    check("k26_events", ev_cnt - base, 1);
    check("k26_out", {28'd0, ev_out}, 32'h3);
    check("k26_flags", {30'd0, ev_flags}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
